// File: rtl/mux_rr_arbiter.sv
//------------------------------------------------------------------------------
// mux_rr_arbiter : two-channel round-robin arbiter with bounded bursts driving
// a registered 2:1 mux output stage. Optional counters: MUX_ARB_STATS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mux_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D0,
    input  logic             D0_valid,
    output logic             D0_ready,
    input  logic [WIDTH-1:0] D1,
    input  logic             D1_valid,
    output logic             D1_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Y_valid,
    input  logic             Y_ready,
    output logic             S0,
    output logic [15:0]      CNT0,
    output logic [15:0]      CNT1
);

    localparam int              c_BW  = $clog2(MAX_BURST + 1);
    localparam logic [c_BW-1:0] c_MAX = c_BW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [c_BW-1:0]  burst_q, burst_d;
    logic [WIDTH-1:0] y_q;
    logic             y_valid_q;

    logic             out_free;
    logic             xfer0, xfer1, xfer;
    logic             cur_valid, oth_valid;
    logic [c_BW-1:0]  nc;

    assign out_free  = !y_valid_q | Y_ready;
    assign D0_ready  = (state_q == GRANT0) & out_free;
    assign D1_ready  = (state_q == GRANT1) & out_free;
    assign xfer0     = D0_valid & D0_ready;
    assign xfer1     = D1_valid & D1_ready;
    assign xfer      = xfer0 | xfer1;
    assign cur_valid = (state_q == GRANT1) ? D1_valid : D0_valid;
    assign oth_valid = (state_q == GRANT1) ? D0_valid : D1_valid;
    assign nc        = burst_q + c_BW'(xfer);

    assign Y       = y_q;
    assign Y_valid = y_valid_q;
    assign S0      = (state_q == GRANT1);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                // On a tie the channel that was not served last wins.
                if (D0_valid && D1_valid) begin
                    state_d = last_q ? GRANT0 : GRANT1;
                    last_d  = !last_q;
                    burst_d = '0;
                end else if (D0_valid) begin
                    state_d = GRANT0;
                    last_d  = 1'b0;
                    burst_d = '0;
                end else if (D1_valid) begin
                    state_d = GRANT1;
                    last_d  = 1'b1;
                    burst_d = '0;
                end
            end
            GRANT0, GRANT1: begin
                if (nc == c_MAX) begin
                    burst_d = '0;
                    if (oth_valid) begin
                        state_d = (state_q == GRANT1) ? GRANT0 : GRANT1;
                        last_d  = (state_q != GRANT1);
                    end
                end else if (!cur_valid) begin
                    burst_d = '0;
                    if (oth_valid) begin
                        state_d = (state_q == GRANT1) ? GRANT0 : GRANT1;
                        last_d  = (state_q != GRANT1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    burst_d = nc;
                end
            end
            default: begin
                state_d = IDLE;
                burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    // A new word may overwrite the held one in the same cycle it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else if (xfer) begin
            y_q       <= xfer1 ? D1 : D0;
            y_valid_q <= 1'b1;
        end else if (Y_ready) begin
            y_valid_q <= 1'b0;
        end
    end

`ifdef MUX_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (xfer0 && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
            if (xfer1 && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign CNT0 = cnt0_q;
    assign CNT1 = cnt1_q;
`else
    assign CNT0 = 16'd0;
    assign CNT1 = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
//------------------------------------------------------------------------------
// tb_mux_rr_arbiter : directed vector table plus hand-written corner sequences.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] D0, D1;
    logic       D0_valid, D1_valid, D0_ready, D1_ready;
    logic [7:0] Y;
    logic       Y_valid, Y_ready, S0;
    logic [15:0] CNT0, CNT1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .D0       (D0),
        .D0_valid (D0_valid),
        .D0_ready (D0_ready),
        .D1       (D1),
        .D1_valid (D1_valid),
        .D1_ready (D1_ready),
        .Y        (Y),
        .Y_valid  (Y_valid),
        .Y_ready  (Y_ready),
        .S0       (S0),
        .CNT0     (CNT0),
        .CNT1     (CNT1)
    );

    typedef struct {
        logic [7:0] d0;
        logic       d0v;
        logic [7:0] d1;
        logic       d1v;
        logic       yr;
        logic       e_d0r;
        logic       e_d1r;
        logic       e_s0;
        logic       e_yv;
        logic [7:0] e_y;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [7:0] d0, input logic d0v, input logic [7:0] d1,
                       input logic d1v, input logic yr, input logic e_d0r,
                       input logic e_d1r, input logic e_s0, input logic e_yv,
                       input logic [7:0] e_y);
        vec_t v;
        v.d0 = d0; v.d0v = d0v; v.d1 = d1; v.d1v = d1v; v.yr = yr;
        v.e_d0r = e_d0r; v.e_d1r = e_d1r; v.e_s0 = e_s0; v.e_yv = e_yv; v.e_y = e_y;
        vt.push_back(v);
    endtask

    initial begin
        // Each row: inputs held for one cycle, expectations seen before the edge.
        //   d0    d0v d1    d1v yr  d0r d1r s0  yv  y
        for (int i = 0; i < 5; i++)
            add(8'h00, 0, 8'h00, 0, 1,  0,  0,  0,  0, 8'h00);   // idle after reset
        add(8'hA5, 1, 8'h00, 0, 1,  0,  0,  0,  0, 8'h00);       // IDLE -> GRANT0
        add(8'hA5, 1, 8'h00, 0, 1,  1,  0,  0,  0, 8'h00);       // accept A5
        add(8'h00, 0, 8'h00, 0, 1,  1,  0,  0,  1, 8'hA5);       // Y=A5, -> IDLE
        add(8'h00, 0, 8'h00, 0, 1,  0,  0,  0,  0, 8'hA5);
        add(8'h10, 1, 8'h21, 1, 1,  0,  0,  0,  0, 8'hA5);       // tie, last=0 -> GRANT1
        add(8'h10, 1, 8'h21, 1, 1,  0,  1,  1,  0, 8'hA5);
        add(8'h10, 1, 8'h22, 1, 1,  0,  1,  1,  1, 8'h21);
        add(8'h10, 1, 8'h23, 1, 1,  0,  1,  1,  1, 8'h22);
        add(8'h10, 1, 8'h24, 1, 1,  0,  1,  1,  1, 8'h23);       // 4th word -> GRANT0
        add(8'h10, 1, 8'h25, 1, 1,  1,  0,  0,  1, 8'h24);
        add(8'h11, 1, 8'h25, 1, 1,  1,  0,  0,  1, 8'h10);
        add(8'h12, 1, 8'h25, 1, 1,  1,  0,  0,  1, 8'h11);
        add(8'h13, 1, 8'h25, 1, 0,  0,  0,  0,  1, 8'h12);       // stall, burst=3 frozen
        add(8'h13, 1, 8'h25, 1, 0,  0,  0,  0,  1, 8'h12);
        add(8'h13, 1, 8'h25, 1, 1,  1,  0,  0,  1, 8'h12);       // 4th D0 word -> GRANT1
        add(8'h14, 1, 8'h25, 1, 1,  0,  1,  1,  1, 8'h13);
        add(8'h14, 1, 8'h00, 0, 1,  0,  1,  1,  1, 8'h25);       // D1 withdraws -> GRANT0
        add(8'h14, 1, 8'h00, 0, 1,  1,  0,  0,  0, 8'h25);
        add(8'h00, 0, 8'h00, 0, 0,  0,  0,  0,  1, 8'h14);       // both idle -> IDLE
        add(8'h00, 0, 8'h00, 0, 1,  0,  0,  0,  1, 8'h14);
        add(8'h00, 0, 8'h00, 0, 1,  0,  0,  0,  0, 8'h14);

        rst_n = 1'b0; D0 = '0; D1 = '0; D0_valid = 0; D1_valid = 0; Y_ready = 1;
        cyc();
        cyc();
        chk("reset_Y_valid", Y_valid, 0);
        chk("reset_S0", S0, 0);
        chk("reset_Y", Y, 8'h00);
        chk("reset_CNT0", CNT0, 0);
        chk("reset_CNT1", CNT1, 0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            D0 = vt[i].d0; D0_valid = vt[i].d0v;
            D1 = vt[i].d1; D1_valid = vt[i].d1v;
            Y_ready = vt[i].yr;
            #2;
            chk($sformatf("vec%0d_D0_ready", i), D0_ready, vt[i].e_d0r);
            chk($sformatf("vec%0d_D1_ready", i), D1_ready, vt[i].e_d1r);
            chk($sformatf("vec%0d_S0", i), S0, vt[i].e_s0);
            chk($sformatf("vec%0d_Y_valid", i), Y_valid, vt[i].e_yv);
            chk($sformatf("vec%0d_Y", i), Y, vt[i].e_y);
            cyc();
        end

`ifdef MUX_ARB_STATS_EN
        chk("stats_CNT0_after_table", CNT0, 16'd6);
        chk("stats_CNT1_after_table", CNT1, 16'd5);
`else
        chk("nostats_CNT0_tied", CNT0, 16'd0);
        chk("nostats_CNT1_tied", CNT1, 16'd0);
`endif

        // Back-pressure in GRANT1: burst count must survive the stall.
        D1 = 8'h3C; D1_valid = 1; D0_valid = 0; Y_ready = 1;
        #2 chk("bp_idle_S0", S0, 0);
        cyc();
        #2 chk("bp_grant1_S0", S0, 1);
        chk("bp_grant1_ready", D1_ready, 1);
        cyc();
        D1 = 8'h3D; Y_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("bp_stall%0d_ready", k), D1_ready, 0);
            chk($sformatf("bp_stall%0d_Y", k), Y, 8'h3C);
            chk($sformatf("bp_stall%0d_Y_valid", k), Y_valid, 1);
            cyc();
        end
        Y_ready = 1;
        #2 chk("bp_release_ready", D1_ready, 1);
        cyc();
        chk("bp_next_word", Y, 8'h3D);
        D1 = 8'h3E; D0 = 8'h77; D0_valid = 1;
        cyc();
        D1 = 8'h3F;
        #2 chk("bp_burst3_S0", S0, 1);
        chk("bp_burst3_Y", Y, 8'h3E);
        cyc();
        #2 chk("bp_switch_S0", S0, 0);
        chk("bp_switch_Y", Y, 8'h3F);
        chk("bp_switch_D0_ready", D0_ready, 1);

        // Withdraw D0 under back-pressure, land in GRANT1 holding Y, then async reset.
        D0_valid = 0; Y_ready = 0;
        cyc();
        #2 chk("mid_S0", S0, 1);
        chk("mid_Y_valid", Y_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_Y_valid", Y_valid, 0);
        chk("async_S0", S0, 0);
        chk("async_Y", Y, 8'h00);
        chk("async_D1_ready", D1_ready, 0);
        chk("async_CNT0", CNT0, 0);
        chk("async_CNT1", CNT1, 0);
        cyc();
        D1_valid = 0; Y_ready = 1;
        rst_n = 1'b1;
        cyc();
        #2 chk("post_reset_S0", S0, 0);
        chk("post_reset_Y_valid", Y_valid, 0);

`ifdef MUX_ARB_STATS_EN
        D1 = 8'h55; D1_valid = 1; Y_ready = 1;
        cyc();
        cyc();
        chk("stats_CNT1_one", CNT1, 16'd1);
        repeat (70000) cyc();
        chk("stats_CNT1_sat", CNT1, 16'hFFFF);
        chk("stats_CNT0_zero", CNT0, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Sequential front end for a 2-to-1 multiplexer datapath. Two valid/ready source channels compete for a single output.
- Round-robin arbitration with bounded bursts. Drives the select line S0 that the downstream 2:1 mux stage consumes.
- Also registers the selected word, so the output is a clean one-entry valid/ready stage.

Parameters:
- WIDTH, 8, data width of D0, D1, Y.
- MAX_BURST, 4, maximum consecutive transfers granted to one channel while the other is requesting. Legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- D0  in  WIDTH  channel 0 data
- D0_valid  in  1  channel 0 has data
- D0_ready  out  1  channel 0 accepted this cycle when D0_valid=1
- D1  in  WIDTH  channel 1 data
- D1_valid  in  1  channel 1 has data
- D1_ready  out  1  channel 1 accepted this cycle when D1_valid=1
- Y  out  WIDTH  registered output data
- Y_valid  out  1  Y holds a word
- Y_ready  in  1  downstream accepts Y
- S0  out  1  current grant: 0 = channel 0, 1 = channel 1
- CNT0  out  16  channel 0 transfer count (optional feature)
- CNT1  out  16  channel 1 transfer count (optional feature)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=IDLE, burst_cnt=0, last=1 (channel 0 wins the first tie).
  - Y=0, Y_valid=0, S0=0, CNT0=CNT1=0.
  - Release of rst_n is honoured on the next rising edge.
  - Reset mid-burst discards any held Y word and the current grant.
- States: IDLE, GRANT0, GRANT1. S0=1 only in GRANT1.
- Readiness: out_free = !Y_valid | Y_ready.
  - D0_ready = (state==GRANT0) & out_free.
  - D1_ready = (state==GRANT1) & out_free.
  - Both readies are always 0 in IDLE.
- Transfer: xfer = Dx_valid & Dx_ready for the granted x.
  - On xfer: Y<=Dx, Y_valid<=1. Latency is 1 cycle from input handshake to Y_valid.
  - Else if Y_ready: Y_valid<=0. Y keeps its last value.
  - Simultaneous Y_ready and new xfer: the new word replaces the old one with no bubble, giving full throughput.
- IDLE transitions:
  - Both valid: grant to !last.
  - Only one valid: grant to that channel.
  - None valid: stay in IDLE.
  - On entering GRANTx: last<=x, burst_cnt<=0. One idle-to-grant cycle costs no data.
- GRANTx transitions, evaluated each edge. Let nc = burst_cnt + xfer.
  - nc==MAX_BURST and other channel valid: go to GRANT_other, burst_cnt<=0, last<=other.
  - nc==MAX_BURST and other channel idle: stay in GRANTx, burst_cnt<=0 (a new burst starts).
  - Dx_valid=0 and other channel valid: go to GRANT_other, burst_cnt<=0.
  - Dx_valid=0 and other channel idle: go to IDLE.
  - Otherwise: stay, burst_cnt<=nc.
- Stall: when Y_valid=1 and Y_ready=0, no xfer occurs, burst_cnt holds, and the grant holds while Dx_valid stays 1.
- Source rules: sources must hold Dx and Dx_valid until accepted. Dropping Dx_valid before acceptance is legal and treated as withdrawal.
- burst_cnt width: $clog2(MAX_BURST+1). It never exceeds MAX_BURST-1 when registered.

Optional Feature:
- MUX_ARB_STATS_EN defined:
  - CNT0 and CNT1 each increment by 1 on every accepted transfer of their channel.
  - Both saturate at 16'hFFFF and clear on reset.
- Not defined:
  - CNT0 and CNT1 are tied to 0 and no counter flops are built.
  - Port list is unchanged.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with both valids 0, then release.
  -> Y_valid=0, S0=0, readies 0, state stays IDLE for 5 cycles.
- Single channel: D0=8'hA5, D0_valid=1, Y_ready=1.
  -> GRANT0 after 1 cycle, D0_ready=1, Y=8'hA5 with Y_valid=1 on the following edge, S0=0.
- Tie and round-robin: both valid continuously with Y_ready=1, MAX_BURST=4.
  -> Y sequence is 4 words from D0, then 4 from D1, alternating.
  -> S0 toggles every 4 transfers; no idle cycle between bursts.
- Back-pressure: Y_ready=0 for 3 cycles while in GRANT1 with D1=8'h3C pending.
  -> D1_ready=0, Y holds its first word, burst_cnt frozen.
  -> On Y_ready=1, the next word transfers with no loss or duplication.
- Withdrawal: in GRANT0, D0_valid drops while D1_valid=1.
  -> Next state GRANT1, S0=1. If D1_valid=0 as well -> IDLE.
- Reset mid-burst: assert rst_n=0 asynchronously in GRANT1 with Y_valid=1.
  -> Y_valid, S0, Y and CNT0/CNT1 go to 0 immediately, without waiting for a clock.
  -> Stats build: CNT1=1 after 1 transfer; 70000 D1 transfers -> CNT1=16'hFFFF.
